// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the common baud
// divisor, so that the TX and RX sides agree on one bit period.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  // 100 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_dev_if.sv
// Byte-stream handshake between the UART receiver and its consumer, together with
// the one-cycle error strobes that travel alongside it.
interface uart_rx_dev_if;
  import uart_pkg::*;

  logic                      rx_valid;
  logic                      rx_ready;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    output rx_valid,
    output rx_data,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_path.sv
// Serial front end of the UART receiver: synchronizer, start-bit validation,
// mid-bit sampling of the data bits and stop-bit evaluation.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] byte_o,
  output logic                      byte_done,
  output logic                      frame_err
);

  localparam int                CW        = $clog2(CLKS_PER_BIT);
  localparam int                BW        = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0]     BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]     HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]     IDX_LAST  = BW'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]    sync_p0;
  logic                      rx_s;
  uart_rx_state_e            state;
  logic [CW-1:0]             bcnt;
  logic [BW-1:0]             bidx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      bit_tick;
  logic                      stop_tick;

  // Synchronizer stage: idle-high line, so the chain resets to all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s      = sync_p0[SYNC_STAGES-1];
  assign bit_tick  = (bcnt == BIT_LAST);
  assign stop_tick = (state == STOP) && bit_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bcnt  <= '0;
      bidx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bcnt <= '0;
          bidx <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          // Half-bit check rejects glitches shorter than half a bit period
          if (bcnt == HALF_LAST) begin
            bcnt  <= '0;
            bidx  <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            bcnt <= '0;
            bidx <= bidx + 1'b1;
            if (bidx == IDX_LAST) begin
              state <= STOP;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            bcnt  <= '0;
            state <= IDLE;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          bcnt  <= '0;
          bidx  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // LSB arrives first: shift in at the MSB so bit 0 ends up holding it
  always_ff @(posedge clk) begin
    if ((state == DATA) && bit_tick) begin
      shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
    end
  end

  // Strobes decode registered state, so the buffer can load on the sampling edge
  assign byte_o    = shreg;
  assign byte_done = stop_tick && rx_s;
  assign frame_err = stop_tick && !rx_s;

endmodule

// File: rtl/uart_rx_dev.sv
// 8N1 UART receiver device: serial front end plus a one-byte output buffer with
// valid/ready handshake, framing-error and overrun strobes.
module uart_rx_dev
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_i,
  uart_rx_dev_if.master rx
);

  logic [UART_DATA_BITS-1:0] path_byte;
  logic                      path_done;
  logic                      path_ferr;
  logic                      consume;
  logic                      load;
  logic                      drop;

  uart_rx_path #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_path (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .byte_o    (path_byte),
    .byte_done (path_done),
    .frame_err (path_ferr)
  );

  // A buffer being drained on this edge counts as free for the incoming byte
  assign consume = rx.rx_valid && rx.rx_ready;
  assign load    = path_done && (!rx.rx_valid || rx.rx_ready);
  assign drop    = path_done && rx.rx_valid && !rx.rx_ready;

  // Output buffer stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rx.rx_valid  <= 1'b0;
      rx.rx_data   <= '0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      rx.frame_err <= path_ferr;
      rx.overrun   <= drop;
      if (load) begin
        rx.rx_valid <= 1'b1;
        rx.rx_data  <= path_byte;
      end else if (consume) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule
